// File: rtl/xaxis_tilt_filter.sv
// xaxis_tilt_filter: clamps new X-axis samples, keeps a sliding moving average and drives tilt LEDs.
module xaxis_tilt_filter #(
  parameter int AVG_LOG2 = 3,
  parameter int DEADBAND = 16
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA_L,
  input  logic [7:0] iDATA_H,
  output logic [9:0] oAVG,
  output logic       oAVG_VALID,
  output logic [7:0] oLED
);
  localparam int N = 1 << AVG_LOG2;
  localparam int SW = 10 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(N);

  typedef enum logic [1:0] {IDLE, UPDATE, PUBLISH} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              word, last_q, last_d;
  logic                     armed_q, armed_d;
  logic signed [9:0]        sample_q, sample_d, clamp;
  logic signed [9:0]        buf_q [N];
  logic [AVG_LOG2-1:0]      wr_q, wr_d;
  logic [AVG_LOG2:0]        fill_q, fill_d;
  logic signed [SW-1:0]     sum_q, sum_d;
  logic [9:0]               avg, avg_q, avg_d;
  logic [10:0]              avg_abs;
  logic [7:0]               led_map, led_q, led_d;
  logic                     valid_q, valid_d;

  assign word = {iDATA_H, iDATA_L};
  assign clamp = $signed(word) > 16'sd511  ? 10'h1FF :
                 $signed(word) < -16'sd512 ? 10'h200 : word[9:0];
  // Dropping the low AVG_LOG2 bits is the floor-toward-minus-infinity divide.
  assign avg = sum_q[SW-1:AVG_LOG2];
  assign avg_abs = avg[9] ? ~{1'b1, avg} + 11'd1 : {1'b0, avg};
  // (avg + 512) >> 7 is just the top three bits with the sign flipped.
  assign led_map = avg_abs < 11'(DEADBAND) ? 8'h18 : 8'd1 << {~avg[9], avg[8:7]};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    armed_d  = armed_q;
    sample_d = sample_q;
    wr_d     = wr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    led_d    = led_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: if (!armed_q || word != last_q) begin
        last_d   = word;
        sample_d = clamp;
        armed_d  = 1'b1;
        state_d  = UPDATE;
      end
      UPDATE: begin
        sum_d   = sum_q - SW'(buf_q[wr_q]) + SW'(sample_q);
        wr_d    = wr_q + AVG_LOG2'(1);
        fill_d  = fill_q == FULL ? fill_q : fill_q + (AVG_LOG2 + 1)'(1);
        state_d = PUBLISH;
      end
      PUBLISH: begin
        if (fill_q == FULL) begin
          avg_d   = avg;
          led_d   = led_map;
          valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      last_q   <= '0;
      armed_q  <= 1'b0;
      sample_q <= '0;
      wr_q     <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
      led_q    <= 8'h18;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      armed_q  <= armed_d;
      sample_q <= sample_d;
      wr_q     <= wr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (state_q == UPDATE) begin
      buf_q[wr_q] <= sample_q;
    end
  end

  assign oAVG       = avg_q;
  assign oAVG_VALID = valid_q;
  assign oLED       = led_q;
endmodule

// File: tb/tb_xaxis_tilt_filter.sv
// tb_xaxis_tilt_filter: directed vectors with hand-computed averages and LED patterns.
module tb_xaxis_tilt_filter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dl = '0, dh = '0;
  logic [9:0] avg;
  logic       valid;
  logic [7:0] led;
  int         nchk = 0, nfail = 0, vcnt = 0, v0;
  logic [9:0] vavg;
  logic [7:0] vled;

  xaxis_tilt_filter dut (
    .iCLK(clk), .iRST(rst), .iDATA_L(dl), .iDATA_H(dh),
    .oAVG(avg), .oAVG_VALID(valid), .oLED(led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) begin
    vcnt++;
    vavg = avg;
    vled = led;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] w);
    @(posedge clk); #1;
    {dh, dl} = w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] w);
    {dh, dl} = w;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset(16'h0000);
    check("rst_fill", 32'(dut.fill_q), 32'd1);
    check("rst_valid_cnt", vcnt, 0);
    check("rst_led", 32'(led), 32'h18);
    check("rst_avg", 32'(avg), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_hold_fill", 32'(dut.fill_q), 32'd1);

    do_reset(16'd100);
    v0 = vcnt;
    for (int i = 101; i <= 106; i++) feed(16'(i));
    check("ramp_early", vcnt - v0, 0);
    {dh, dl} = 16'd107;
    repeat (3) @(negedge clk);
    check("lat_c2", 32'(valid), 32'h0);
    @(negedge clk);
    check("lat_c3", 32'(valid), 32'h1);
    check("ramp_avg", 32'(avg), 32'd103);
    check("ramp_led", 32'(led), 32'h10);
    @(negedge clk);
    check("lat_c4", 32'(valid), 32'h0);
    @(posedge clk); #1;
    feed(16'd107);
    check("ramp_one_pulse", vcnt - v0, 1);

    feed(16'd200);
    check("slide_cnt", vcnt - v0, 2);
    check("slide_avg", 32'(vavg), 32'd116);
    check("slide_led", 32'(vled), 32'h10);

    do_reset(16'h0300);
    v0 = vcnt;
    for (int i = 1; i < 8; i++) feed(i[0] ? 16'hFC00 : 16'h0300);
    check("clamp_cnt", vcnt - v0, 1);
    check("clamp_avg", 32'(vavg), 32'h3FF);
    check("clamp_led", 32'(vled), 32'h18);

    do_reset(16'hFED4);
    v0 = vcnt;
    for (int i = -299; i <= -293; i++) feed(16'(i));
    check("neg_cnt", vcnt - v0, 1);
    check("neg_avg", 32'(vavg), 32'h2D7);
    check("neg_led", 32'(vled), 32'h02);

    do_reset(16'd10);
    v0 = vcnt;
    for (int i = 11; i <= 16; i++) feed(16'(i));
    {dh, dl} = 16'd17;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_avg", 32'(avg), 32'h0);
    check("abort_led", 32'(led), 32'h18);
    check("abort_valid", 32'(valid), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_nopulse", vcnt - v0, 0);
    check("abort_fill", 32'(dut.fill_q), 32'd1);
    for (int i = 18; i <= 23; i++) feed(16'(i));
    check("abort_refill", vcnt - v0, 0);
    feed(16'd24);
    check("abort_cnt", vcnt - v0, 1);
    check("abort_new_avg", 32'(vavg), 32'd20);
    check("abort_new_led", 32'(vled), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
